// File: rtl/muldiv_unit_ppl.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional accumulate-multiply support is enabled by defining MULDIV_MADD_EN.
`timescale 1ns/1ps
module muldiv_unit_ppl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH-1:0]     ma_q;
    logic [WIDTH-1:0]     mb_q;
    logic [WIDTH-1:0]     a_q;
    logic                 div_q;
    logic                 sgn_q;
    logic                 sa_q;
    logic                 sb_q;
    logic                 bz_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 dz_q;

    logic                 sa_in;
    logic                 sb_in;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

`ifdef MULDIV_MADD_EN
    logic                 acc_q;
`else
    logic                 unused_acc;
    assign unused_acc = acc;
`endif

    // Operand magnitudes at launch; unsigned ops (op[0]=1) pass raw values.
    always_comb begin
        sa_in = ~op[0] & a[WIDTH-1];
        sb_in = ~op[0] & b[WIDTH-1];
        abs_a = sa_in ? -a : a;
        abs_b = sb_in ? -b : b;
    end

    // One shift-add or restoring-divide step on the shared product register.
    always_comb begin
        logic [WIDTH:0] upper;
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        upper   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (prod_q[0] ? ma_q : {WIDTH{1'b0}})};
        shifted = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        diff    = shifted - {1'b0, mb_q};
        prod_d  = {upper, prod_q[WIDTH-1:1]};
        if (div_q) begin
            if (diff[WIDTH])
                prod_d = {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            else
                prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and final HI/LO values committed in FIX.
    always_comb begin
        logic [2*WIDTH-1:0] mres;
        logic [WIDTH-1:0]   quo;
        logic [WIDTH-1:0]   rem;
        mres = (sgn_q & (sa_q ^ sb_q)) ? -prod_q : prod_q;
`ifdef MULDIV_MADD_EN
        if (acc_q)
            mres = mres + {hi_q, lo_q};
`endif
        quo = prod_q[WIDTH-1:0];
        rem = prod_q[2*WIDTH-1:WIDTH];
        if (sgn_q & (sa_q ^ sb_q))
            quo = -quo;
        if (sgn_q & sa_q)
            rem = -rem;
        if (!div_q) begin
            hi_d = mres[2*WIDTH-1:WIDTH];
            lo_d = mres[WIDTH-1:0];
        end else if (bz_q) begin
            hi_d = a_q;
            lo_d = {WIDTH{1'b1}};
        end else begin
            hi_d = rem;
            lo_d = quo;
        end
    end

    // Control FSM, datapath registers and architectural HI/LO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            a_q     <= '0;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_q   <= 1'b0;
`endif
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            if (hi_we)
                hi_q <= wdata;
            if (lo_we)
                lo_q <= wdata;
            if (flush) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            ma_q    <= abs_a;
                            mb_q    <= abs_b;
                            a_q     <= a;
                            div_q   <= op[1];
                            sgn_q   <= ~op[0];
                            sa_q    <= sa_in;
                            sb_q    <= sb_in;
                            bz_q    <= (b == '0);
`ifdef MULDIV_MADD_EN
                            acc_q   <= acc & ~op[1];
`endif
                            prod_q  <= op[1] ? {{WIDTH{1'b0}}, abs_a}
                                             : {{WIDTH{1'b0}}, abs_b};
                            cnt_q   <= CNT_W'(WIDTH - 1);
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        prod_q <= prod_d;
                        if (cnt_q == '0)
                            state_q <= S_FIX;
                        else
                            cnt_q <= cnt_q - 1'b1;
                    end
                    S_FIX: begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        done_q  <= 1'b1;
                        dz_q    <= div_q & bz_q;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit_ppl.md
Name: muldiv_unit_ppl

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the five-stage pipeline.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and raises busy so the ID stage stalls until the result exists.
- Sits beside the EX stage. HI/LO outputs feed the MFHI/MFLO path and its forwarding logic.
- Generalises the single-cycle 32-bit multiplier to any WIDTH and adds division, MTHI/MTLO writes, flush and divide-by-zero flagging.

Parameters:
- WIDTH, 32: operand width. HI, LO and the operands are each WIDTH bits. Minimum 4.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- acc  in  1  accumulate request; meaningful only with MULDIV_MADD_EN.
- flush  in  1  abort any in-flight operation.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO just committed.
- dz  out  1  divide-by-zero flag, valid with done.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, dz=0, counter=0. Reset mid-operation discards it.
- FSM states: IDLE, RUN, FIX. busy = (state != IDLE), registered.
- IDLE, start=1, flush=0:
  - Latch |a| and |b|; signed ops take two's-complement magnitudes, unsigned ops take raw values.
  - Latch the op, sign bits and acc; load counter = WIDTH-1; go to RUN.
- RUN, one iteration per edge:
  - Multiply: radix-2 shift-add into a 2*WIDTH-bit partial product.
  - Divide: restoring, one quotient bit per edge.
  - When counter reaches 0, go to FIX. RUN therefore lasts exactly WIDTH edges.
- FIX, on one edge: apply sign correction, commit hi/lo, assert done=1 for exactly the following cycle, return to IDLE.
- Latency: start sampled at edge E0 gives done=1 and new hi/lo visible after edge E0+WIDTH+1. For WIDTH=32 that is 33 cycles. busy is high for WIDTH+1 cycles.
- Sign and result rules:
  - MULT: product negated when a and b signs differ. {hi,lo} = 2*WIDTH-bit product.
  - DIV: quotient negated when signs differ; remainder takes the dividend's sign. lo = quotient, hi = remainder.
  - Signed min / -1: lo = min (e.g. 0x80000000), hi = 0, no flag.
  - b==0, any divide: lo = all ones, hi = a unmodified, dz=1 alongside done. Latency unchanged.
- start while busy: ignored. The pipeline must hold the instruction using busy.
- flush: state goes to IDLE on the next edge. hi/lo unchanged, no done.
  - flush and start in the same IDLE cycle: flush wins and start is ignored.
  - flush in FIX: commit suppressed.
- hi_we / lo_we: write wdata to hi / lo on the edge, in any state.
  - If an operation later commits in FIX, the commit overwrites both registers.
  - A write in the same edge as the FIX commit loses to the commit.
- done and dz are 0 in every cycle other than the post-FIX cycle.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined: a multiply started with acc=1 commits {hi,lo} <= {hi,lo} + product, mod 2^(2*WIDTH). HI/LO are sampled at the FIX edge, so MTHI/MTLO writes issued during RUN are included. acc with a divide is ignored.
- Undefined: the acc port is ignored and multiplies always overwrite.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 (WIDTH=32) -> busy 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA, dz=0.
- MULTU a=0xFFFFFFFE, b=3 -> hi=0x00000002, lo=0xFFFFFFFA. Second start pulsed during busy has no effect.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> after 33 cycles done=1, dz=1, lo=0xFFFFFFFF, hi=5.
- MTHI 0x1234 in IDLE -> hi=0x1234 next edge. Start MULTU, flush at RUN cycle 10 -> busy=0 next edge, hi stays 0x1234, no done. Repeat with rst pulsed low mid-RUN -> hi=lo=0, busy=0 immediately.
- With MULDIV_MADD_EN: hi=0, lo=5, MULT 2*3 with acc=1 -> lo=11, hi=0. Same without the macro -> lo=6.
